// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: byte-lane steering, single-outstanding data bus, load align/extend.
// Latency: store with immediate ready stalls 1 cycle; load with immediate ready and next-cycle rvalid stalls 2.
// Backpressure: dbus_ready low holds the request stable in REQ; stall_M freezes IF..M until DONE.
// Optional build macro LSU_MISALIGN_TRAP_EN adds misalign_M and suppresses misaligned accesses.
module mem_stage_lsu #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   addr_M,
    input  logic [31:0]   wdata_M,
    input  logic          we_mem_M,
    input  logic [3:0]    ls_type_M,
    input  logic          hold_M,
    output logic          stall_M,
    output logic [31:0]   load_data_M,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic          misalign_M,
`endif
    output logic          dbus_req,
    output logic          dbus_we,
    output logic [AW-1:0] dbus_addr,
    output logic [31:0]   dbus_wdata,
    output logic [3:0]    dbus_be,
    input  logic          dbus_ready,
    input  logic          dbus_rvalid,
    input  logic [31:0]   dbus_rdata
);

    localparam logic [3:0] T_LB  = 4'b0001;
    localparam logic [3:0] T_LH  = 4'b0010;
    localparam logic [3:0] T_LW  = 4'b0011;
    localparam logic [3:0] T_LBU = 4'b0100;
    localparam logic [3:0] T_LHU = 4'b0101;
    localparam logic [3:0] T_SB  = 4'b1001;
    localparam logic [3:0] T_SH  = 4'b1010;
    localparam logic [3:0] T_SW  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   addr_q;
    logic            we_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [3:0]      type_q;
    logic [1:0]      off_q;
    logic [31:0]     load_data_q;

    logic            is_load_c;
    logic            is_store_c;
    logic            access_c;
    logic            misal_c;
    logic            go_c;
    logic [1:0]      off_c;
    logic [AW-1:0]   req_addr_c;
    logic [3:0]      req_be_c;
    logic [31:0]     req_wdata_c;
    logic [7:0]      lane_b_c;
    logic [15:0]     lane_h_c;
    logic [31:0]     ext_c;

    // Decode the M-stage access and build the lane-steered request fields.
    always_comb begin
        is_load_c   = 1'b0;
        is_store_c  = 1'b0;
        req_be_c    = 4'b1111;
        req_wdata_c = 32'h0;
        off_c       = addr_M[1:0];
        req_addr_c  = {addr_M[AW-1:2], 2'b00};
        case (ls_type_M)
            T_LB, T_LH, T_LW, T_LBU, T_LHU: is_load_c = 1'b1;
            T_SB: begin
                is_store_c  = 1'b1;
                req_be_c    = 4'b0001 << off_c;
                req_wdata_c = {4{wdata_M[7:0]}};
            end
            T_SH: begin
                is_store_c  = 1'b1;
                req_be_c    = 4'b0011 << {off_c[1], 1'b0};
                req_wdata_c = {2{wdata_M[15:0]}};
            end
            T_SW: begin
                is_store_c  = 1'b1;
                req_wdata_c = wdata_M;
            end
            default: ;
        endcase
        // A type whose direction disagrees with we_mem_M is treated as no access.
        access_c = (is_load_c & ~we_mem_M) | (is_store_c & we_mem_M);
`ifdef LSU_MISALIGN_TRAP_EN
        misal_c = (((ls_type_M == T_LH) || (ls_type_M == T_LHU) || (ls_type_M == T_SH)) && off_c[0])
               || (((ls_type_M == T_LW) || (ls_type_M == T_SW)) && (off_c != 2'b00));
`else
        // Without trapping, halfwords use off[1] only and words ignore the offset.
        misal_c = 1'b0;
`endif
        go_c = access_c & ~misal_c;
    end

    // Align the returned word for the captured access and sign/zero-extend it.
    always_comb begin
        lane_b_c = dbus_rdata[{off_q, 3'b000} +: 8];
        lane_h_c = dbus_rdata[{off_q[1], 4'b0000} +: 16];
        case (type_q)
            T_LB:    ext_c = {{24{lane_b_c[7]}}, lane_b_c};
            T_LBU:   ext_c = {24'h0, lane_b_c};
            T_LH:    ext_c = {{16{lane_h_c[15]}}, lane_h_c};
            T_LHU:   ext_c = {16'h0, lane_h_c};
            default: ext_c = dbus_rdata;
        endcase
    end

    // Access FSM; request fields are registered on entry so REQ holds them stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            type_q      <= 4'h0;
            off_q       <= 2'b00;
            load_data_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go_c) begin
                        addr_q  <= req_addr_c;
                        we_q    <= we_mem_M;
                        wdata_q <= req_wdata_c;
                        be_q    <= req_be_c;
                        type_q  <= ls_type_M;
                        off_q   <= off_c;
                        if (dbus_ready) begin
                            state_q <= we_mem_M ? S_DONE : S_WAIT;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (dbus_ready) begin
                        state_q <= we_q ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // rvalid is only looked at after the accept cycle.
                    if (dbus_rvalid) begin
                        load_data_q <= ext_c;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Held instruction stays retired here; no re-issue while hold_M.
                    if (!hold_M) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Bus outputs: live request in IDLE, registered copy in REQ, quiet otherwise.
    always_comb begin
        dbus_req   = 1'b0;
        dbus_we    = 1'b0;
        dbus_addr  = '0;
        dbus_wdata = 32'h0;
        dbus_be    = 4'h0;
        case (state_q)
            S_IDLE: begin
                if (go_c) begin
                    dbus_req   = 1'b1;
                    dbus_we    = we_mem_M;
                    dbus_addr  = req_addr_c;
                    dbus_wdata = req_wdata_c;
                    dbus_be    = req_be_c;
                end
            end
            S_REQ: begin
                dbus_req   = 1'b1;
                dbus_we    = we_q;
                dbus_addr  = addr_q;
                dbus_wdata = wdata_q;
                dbus_be    = be_q;
            end
            default: ;
        endcase
        stall_M = go_c & (state_q != S_DONE);
    end

    assign load_data_M = load_data_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_M = access_c & misal_c;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr_M;
    logic [31:0] wdata_M;
    logic        we_mem_M;
    logic [3:0]  ls_type_M;
    logic        hold_M;
    logic        stall_M;
    logic [31:0] load_data_M;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ready;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;

    mem_stage_lsu #(.AW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr_M      (addr_M),
        .wdata_M     (wdata_M),
        .we_mem_M    (we_mem_M),
        .ls_type_M   (ls_type_M),
        .hold_M      (hold_M),
        .stall_M     (stall_M),
        .load_data_M (load_data_M),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_addr   (dbus_addr),
        .dbus_wdata  (dbus_wdata),
        .dbus_be     (dbus_be),
        .dbus_ready  (dbus_ready),
        .dbus_rvalid (dbus_rvalid),
        .dbus_rdata  (dbus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ty;
        logic        we;
        logic        hold;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          rv_dly;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] ld;
        int          stall;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];
    vec_t exp_q [$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    // Drives one access, acts as the bus slave, and scores it against the queued expectation.
    task automatic run_vec(input int idx, input vec_t v);
        int   req_cyc;
        int   stall_cyc;
        int   age;
        int   exp_req;
        bit   done;
        bit   acc;
        logic is_ld;
        vec_t e;
        is_ld = (v.ty >= 4'd1) && (v.ty <= 4'd5) && !v.we;
        exp_q.push_back(v);
        ls_type_M   = v.ty;
        we_mem_M    = v.we;
        addr_M      = v.addr;
        wdata_M     = v.wdata;
        hold_M      = v.hold;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0;
        dbus_ready  = (v.rdy_dly == 0);
        req_cyc     = 0;
        stall_cyc   = 0;
        age         = -1;
        done        = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            #1;
            e = exp_q[0];
            if (!stall_M) begin
                done    = 1'b1;
                exp_req = (e.stall == 0) ? 0 : e.rdy_dly + 1;
                chk($sformatf("v%0d_stall_cycles", idx), 32'(stall_cyc), 32'(e.stall));
                chk($sformatf("v%0d_req_cycles", idx), 32'(req_cyc), 32'(exp_req));
                if (is_ld)
                    chk($sformatf("v%0d_load_data", idx), load_data_M, e.ld);
                if (e.stall == 0) begin
                    chk($sformatf("v%0d_idle_req", idx), 32'(dbus_req), 32'h0);
                    chk($sformatf("v%0d_idle_be", idx), 32'(dbus_be), 32'h0);
                end
                hold_M = 1'b0;
                e = exp_q.pop_front();
            end else begin
                stall_cyc++;
                if (dbus_req) begin
                    req_cyc++;
                    chk($sformatf("v%0d_addr", idx), dbus_addr, {e.addr[31:2], 2'b00});
                    chk($sformatf("v%0d_be", idx), 32'(dbus_be), 32'(e.be));
                    chk($sformatf("v%0d_we", idx), 32'(dbus_we), 32'(e.we));
                    if (e.we)
                        chk($sformatf("v%0d_wdata", idx), dbus_wdata, e.bwdata);
                end
                acc = dbus_req && dbus_ready;
                @(posedge clk); #1;
                if (age >= 0) age++;
                if (acc) age = 1;
                dbus_ready  = (req_cyc >= v.rdy_dly);
                dbus_rvalid = is_ld && (age == v.rv_dly);
                dbus_rdata  = dbus_rvalid ? v.rdata : 32'h0;
            end
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL v%0d_timeout: stall_M still %b, expected release", idx, stall_M);
            e = exp_q.pop_front();
        end
        @(posedge clk); #1;
        ls_type_M   = 4'h0;
        we_mem_M    = 1'b0;
        hold_M      = 1'b0;
        dbus_ready  = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0;
    endtask

    initial begin
        int req_cnt;
        //          ty     we    hold  addr           wdata          rdata          rdy rv  be     bwdata         ld             stall
        vecs[0]  = '{4'hB, 1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         0,  0,  4'hF, 32'hDEAD_BEEF, 32'h0,         1};
        vecs[1]  = '{4'h9, 1'b1, 1'b1, 32'h0000_0103, 32'h0000_00A5, 32'h0,         3,  0,  4'h8, 32'hA5A5_A5A5, 32'h0,         4};
        vecs[2]  = '{4'h1, 1'b0, 1'b1, 32'h0000_0102, 32'h0,         32'h1280_4567, 0,  2,  4'hF, 32'h0,         32'hFFFF_FF80, 3};
        vecs[3]  = '{4'h4, 1'b0, 1'b0, 32'h0000_0102, 32'h0,         32'h1280_4567, 0,  2,  4'hF, 32'h0,         32'h0000_0080, 3};
        vecs[4]  = '{4'h2, 1'b0, 1'b0, 32'h0000_0102, 32'h0,         32'h8001_1234, 0,  1,  4'hF, 32'h0,         32'hFFFF_8001, 2};
        vecs[5]  = '{4'h5, 1'b0, 1'b0, 32'h0000_0102, 32'h0,         32'h8001_1234, 0,  1,  4'hF, 32'h0,         32'h0000_8001, 2};
        vecs[6]  = '{4'h3, 1'b0, 1'b0, 32'h0000_0102, 32'h0,         32'h8001_1234, 0,  1,  4'hF, 32'h0,         32'h8001_1234, 2};
        vecs[7]  = '{4'hA, 1'b1, 1'b0, 32'h0000_0102, 32'h0000_BEEF, 32'h0,         1,  0,  4'hC, 32'hBEEF_BEEF, 32'h0,         2};
        vecs[8]  = '{4'h9, 1'b1, 1'b0, 32'h0000_0001, 32'h1234_5677, 32'h0,         0,  0,  4'h2, 32'h7777_7777, 32'h0,         1};
        vecs[9]  = '{4'h1, 1'b0, 1'b0, 32'h0000_0201, 32'h0,         32'h0000_F300, 1,  1,  4'hF, 32'h0,         32'hFFFF_FFF3, 3};
        vecs[10] = '{4'h2, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h1234_7FFE, 2,  3,  4'hF, 32'h0,         32'h0000_7FFE, 6};
        vecs[11] = '{4'hB, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0102_0304, 32'h0,         0,  0,  4'hF, 32'h0102_0304, 32'h0,         1};
        vecs[12] = '{4'h5, 1'b0, 1'b0, 32'h0000_0103, 32'h0,         32'hABCD_0000, 0,  1,  4'hF, 32'h0,         32'h0000_ABCD, 2};
        vecs[13] = '{4'hA, 1'b1, 1'b0, 32'h0000_0001, 32'h0000_1234, 32'h0,         0,  0,  4'h3, 32'h1234_1234, 32'h0,         1};
        vecs[14] = '{4'h3, 1'b1, 1'b0, 32'h0000_0040, 32'h5555_5555, 32'h0,         0,  0,  4'h0, 32'h0,         32'h0,         0};
        vecs[15] = '{4'h9, 1'b0, 1'b0, 32'h0000_0040, 32'h5555_5555, 32'h0,         0,  0,  4'h0, 32'h0,         32'h0,         0};
        vecs[16] = '{4'h7, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h0,         0,  0,  4'h0, 32'h0,         32'h0,         0};
        vecs[17] = '{4'h1, 1'b0, 1'b0, 32'h0000_0103, 32'h0,         32'h7F00_0000, 0,  1,  4'hF, 32'h0,         32'h0000_007F, 2};

        rst_n       = 1'b0;
        addr_M      = 32'h0;
        wdata_M     = 32'h0;
        we_mem_M    = 1'b0;
        ls_type_M   = 4'h0;
        hold_M      = 1'b0;
        dbus_ready  = 1'b0;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall_M), 32'h0);
        chk("rst_req", 32'(dbus_req), 32'h0);
        chk("rst_load_data", load_data_M, 32'h0);
        chk("rst_be", 32'(dbus_be), 32'h0);
        chk("rst_addr", dbus_addr, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            run_vec(i, vecs[i]);
        end

        // LW finishing under a 3-cycle hold: DONE is sticky, one request only, data stable.
        req_cnt     = 0;
        ls_type_M   = 4'h3;
        we_mem_M    = 1'b0;
        addr_M      = 32'h0000_0100;
        hold_M      = 1'b1;
        dbus_ready  = 1'b1;
        #1;
        if (dbus_req) req_cnt++;
        chk("hold_issue_stall", 32'(stall_M), 32'h1);
        @(posedge clk); #1;
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hCAFE_F00D;
        #1;
        if (dbus_req) req_cnt++;
        chk("hold_wait_stall", 32'(stall_M), 32'h1);
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (dbus_req) req_cnt++;
            chk($sformatf("hold_done_stall_%0d", k), 32'(stall_M), 32'h0);
            chk($sformatf("hold_done_data_%0d", k), load_data_M, 32'hCAFE_F00D);
            @(posedge clk); #1;
        end
        hold_M = 1'b0;
        #1;
        if (dbus_req) req_cnt++;
        chk("hold_release_data", load_data_M, 32'hCAFE_F00D);
        @(posedge clk); #1;
        ls_type_M  = 4'h0;
        dbus_ready = 1'b0;
        chk("hold_req_count", 32'(req_cnt), 32'h1);

        // Reset while waiting for read data; a late rvalid must not be captured.
        ls_type_M  = 4'h3;
        addr_M     = 32'h0000_0104;
        dbus_ready = 1'b1;
        @(posedge clk); #1;
        dbus_ready = 1'b0;
        #1;
        chk("rstw_wait_stall", 32'(stall_M), 32'h1);
        chk("rstw_wait_req", 32'(dbus_req), 32'h0);
        rst_n     = 1'b0;
        ls_type_M = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rstw_stall", 32'(stall_M), 32'h0);
        chk("rstw_load_data", load_data_M, 32'h0);
        chk("rstw_req", 32'(dbus_req), 32'h0);
        dbus_rvalid = 1'b1;
        dbus_rdata  = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dbus_rvalid = 1'b0;
        dbus_rdata  = 32'h0;
        #1;
        chk("rstw_late_rvalid_data", load_data_M, 32'h0);
        chk("rstw_late_rvalid_stall", 32'(stall_M), 32'h0);
        @(posedge clk); #1;
        run_vec(100, vecs[3]);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
